clock_time_counter: RTL and testbench

BCD hours/minutes/seconds time-of-day counter for the FPGA clock. It sits directly downstream of the 1 Hz divider and consumes its one-cycle `cy` pulse on the `tick` input. It keeps the 24-hour time HH:MM:SS in packed BCD and supports three ways of changing the time: manual set-mode adjustment, parallel load, and reset to a parameterised time. It drives the display/scan stage and emits rollover pulses.

---
 rtl/clock_time_counter.sv | 119 +++++++++++
 tb/tb_clock_time_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// 24-hour BCD time-of-day counter (HH:MM:SS) advanced by a 1 Hz tick.
// Supports parallel load with validation, set-mode adjustment and rollover pulses.
module clock_time_counter #(
    parameter logic [7:0] RST_HOUR = 8'h00,
    parameter logic [7:0] RST_MIN  = 8'h00,
    parameter logic [7:0] RST_SEC  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_en,
    input  logic       inc_h,
    input  logic       inc_m,
    input  logic       load,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    input  logic [7:0] load_s,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       min_cy,
    output logic       hour_cy,
    output logic       day_cy,
    output logic       load_err
);

    logic [7:0] r_hour, r_min, r_sec;
    logic       r_min_cy, r_hour_cy, r_day_cy, r_load_err;

    logic [7:0] w_hour_nxt, w_min_nxt, w_sec_nxt;
    logic       w_min_cy_nxt, w_hour_cy_nxt, w_day_cy_nxt, w_load_err_nxt;
    logic       w_load_ok;
    logic       w_sec_wrap, w_min_wrap, w_hour_wrap;

    // Wraps to 00 at max_v; otherwise a units 9 rolls into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    assign w_load_ok   = bcd_ok(load_h, 8'h23) && bcd_ok(load_m, 8'h59) && bcd_ok(load_s, 8'h59);
    assign w_sec_wrap  = (r_sec == 8'h59);
    assign w_min_wrap  = w_sec_wrap && (r_min == 8'h59);
    assign w_hour_wrap = w_min_wrap && (r_hour == 8'h23);

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hour_nxt     = r_hour;
        w_min_nxt      = r_min;
        w_sec_nxt      = r_sec;
        w_min_cy_nxt   = 1'b0;
        w_hour_cy_nxt  = 1'b0;
        w_day_cy_nxt   = 1'b0;
        w_load_err_nxt = 1'b0;

        if (load) begin
            if (w_load_ok) begin
                w_hour_nxt = load_h;
                w_min_nxt  = load_m;
                w_sec_nxt  = load_s;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (set_en) begin
            w_sec_nxt = 8'h00;
            if (inc_m) w_min_nxt  = bcd_inc(r_min, 8'h59);
            if (inc_h) w_hour_nxt = bcd_inc(r_hour, 8'h23);
        end else if (tick) begin
            w_sec_nxt = bcd_inc(r_sec, 8'h59);
            if (w_sec_wrap) begin
                w_min_nxt    = bcd_inc(r_min, 8'h59);
                w_min_cy_nxt = 1'b1;
            end
            if (w_min_wrap) begin
                w_hour_nxt    = bcd_inc(r_hour, 8'h23);
                w_hour_cy_nxt = 1'b1;
            end
            w_day_cy_nxt = w_hour_wrap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hour     <= RST_HOUR;
            r_min      <= RST_MIN;
            r_sec      <= RST_SEC;
            r_min_cy   <= 1'b0;
            r_hour_cy  <= 1'b0;
            r_day_cy   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_hour     <= w_hour_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_min_cy   <= w_min_cy_nxt;
            r_hour_cy  <= w_hour_cy_nxt;
            r_day_cy   <= w_day_cy_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign hour     = r_hour;
    assign min      = r_min;
    assign sec      = r_sec;
    assign min_cy   = r_min_cy;
    assign hour_cy  = r_hour_cy;
    assign day_cy   = r_day_cy;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter: reset, rollover, BCD carry,
// set mode, load validation and priority, with hand-computed expected values.
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, set_en, inc_h, inc_m, load;
    logic [7:0] load_h, load_m, load_s;
    logic [7:0] hour, min, sec;
    logic       min_cy, hour_cy, day_cy, load_err;
    logic [7:0] hour2, min2, sec2;
    logic       min_cy2, hour_cy2, day_cy2, load_err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_time_counter dut (
        .clk(clk), .rst(rst), .tick(tick), .set_en(set_en), .inc_h(inc_h), .inc_m(inc_m),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hour(hour), .min(min), .sec(sec),
        .min_cy(min_cy), .hour_cy(hour_cy), .day_cy(day_cy), .load_err(load_err)
    );

    clock_time_counter #(.RST_HOUR(8'h12)) dut_rst12 (
        .clk(clk), .rst(rst), .tick(tick), .set_en(set_en), .inc_h(inc_h), .inc_m(inc_m),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hour(hour2), .min(min2), .sec(sec2),
        .min_cy(min_cy2), .hour_cy(hour_cy2), .day_cy(day_cy2), .load_err(load_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b1; tick = 1'b0; set_en = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
        load = 1'b0; load_h = 8'h00; load_m = 8'h00; load_s = 8'h00;
    endtask

    // Apply the currently driven inputs for one edge, then release the pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        tick = 1'b0; inc_h = 1'b0; inc_m = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; load_h = h; load_m = m; load_s = s;
        cycle();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
    endtask

    task automatic check_time(input string tag, input logic [23:0] exp);
        check(tag, {8'h00, hour, min, sec}, {8'h00, exp});
    endtask

    // Pulse vector order: {min_cy, hour_cy, day_cy, load_err}.
    task automatic check_pulses(input string tag, input logic [3:0] exp);
        check(tag, {28'h0, min_cy, hour_cy, day_cy, load_err}, {28'h0, exp});
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);

        // Reset with defaults and with RST_HOUR=12.
        rst = 1'b0;
        cycle();
        cycle();
        check_time("reset_time", 24'h000000);
        check_pulses("reset_pulses", 4'b0000);
        check("reset_time_h12", {8'h00, hour2, min2, sec2}, 32'h00120000);
        rst = 1'b1;
        cycle();
        check_time("post_reset_hold", 24'h000000);

        // Tick rollover across the day boundary.
        do_load(8'h23, 8'h59, 8'h58);
        check_time("load_235958", 24'h235958);
        do_tick();
        check_time("tick_235959", 24'h235959);
        check_pulses("tick_235959_pulses", 4'b0000);
        do_tick();
        check_time("day_roll_time", 24'h000000);
        check_pulses("day_roll_pulses", 4'b1110);
        cycle();
        check_pulses("day_roll_pulses_clear", 4'b0000);

        // BCD digit carries.
        do_load(8'h09, 8'h09, 8'h09);
        do_tick();
        check_time("bcd_sec_carry", 24'h090910);
        check_pulses("bcd_sec_carry_pulses", 4'b0000);
        do_load(8'h09, 8'h59, 8'h59);
        do_tick();
        check_time("hour_09_to_10", 24'h100000);
        check_pulses("hour_09_to_10_pulses", 4'b1100);
        do_load(8'h19, 8'h59, 8'h59);
        do_tick();
        check_time("hour_19_to_20", 24'h200000);

        // Run mode ignores the adjust inputs.
        inc_m = 1'b1; inc_h = 1'b1;
        cycle();
        check_time("run_inc_ignored", 24'h200000);

        // Set mode.
        do_load(8'h10, 8'h20, 8'h35);
        set_en = 1'b1;
        cycle();
        check_time("set_sec_zero", 24'h102000);
        for (int i = 0; i < 40; i++) begin
            inc_m = 1'b1;
            cycle();
        end
        check_time("set_inc_m_40", 24'h100000);
        for (int i = 0; i < 14; i++) begin
            inc_h = 1'b1;
            cycle();
        end
        check_time("set_inc_h_14", 24'h000000);
        check_pulses("set_no_pulses", 4'b0000);
        do_tick();
        check_time("set_tick_ignored", 24'h000000);
        inc_m = 1'b1; inc_h = 1'b1;
        cycle();
        check_time("set_inc_both", 24'h010100);
        set_en = 1'b0;
        do_tick();
        check_time("set_exit_tick", 24'h010101);

        // Load validation.
        do_load(8'h24, 8'h00, 8'h00);
        check_time("load_h24_rejected", 24'h010101);
        check_pulses("load_h24_err", 4'b0001);
        cycle();
        check_pulses("load_err_clear", 4'b0000);
        do_load(8'h1A, 8'h00, 8'h00);
        check_time("load_1A_rejected", 24'h010101);
        check_pulses("load_1A_err", 4'b0001);
        do_load(8'h00, 8'h60, 8'h00);
        check_pulses("load_m60_err", 4'b0001);
        tick = 1'b1;
        do_load(8'h23, 8'h59, 8'h59);
        check_time("load_with_tick", 24'h235959);
        check_pulses("load_with_tick_pulses", 4'b0000);

        // Priority: reset beats load.
        rst = 1'b0;
        do_load(8'h24, 8'h00, 8'h00);
        check_time("rst_over_load_time", 24'h000000);
        check_pulses("rst_over_load_err", 4'b0000);
        rst = 1'b1;

        // Reset in the middle of set mode.
        do_load(8'h05, 8'h06, 8'h07);
        set_en = 1'b1;
        cycle();
        check_time("set_before_rst", 24'h050600);
        rst = 1'b0; inc_m = 1'b1; inc_h = 1'b1;
        cycle();
        check_time("rst_in_set_time", 24'h000000);
        check_pulses("rst_in_set_pulses", 4'b0000);
        rst = 1'b1; set_en = 1'b0;
        do_tick();
        check_time("run_after_rst", 24'h000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
